// File: rtl/sap_sequencer.sv
// sap_sequencer: Moore fetch/decode/execute controller (CLK,RESET,RUN,OPCODE,MEM_ACK in; bus strobes,ALU_OP,HALTED,FAULT,STATE,RETIRED out)
module sap_sequencer #(
  parameter int WAIT_MAX = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic [3:0] OPCODE,
  input  logic       MEM_ACK,
  output logic       OE_PC,
  output logic       PC_INC,
  output logic       WE_MAR,
  output logic       MEM_RD,
  output logic       OE_MEM,
  output logic       WE_IR,
  output logic       OE_IR,
  output logic       WE_ACC,
  output logic       OE_ACC,
  output logic       WE_BREG,
  output logic       OE_ALU,
  output logic [2:0] ALU_OP,
  output logic       WE_OR,
  output logic       HALTED,
  output logic       FAULT,
  output logic [3:0] STATE,
  output logic [7:0] RETIRED
);
  typedef enum logic [3:0] {
    s_idle, s_f_addr, s_f_wait, s_f_load, s_decode, s_o_addr,
    s_o_wait, s_o_load, s_alu_wb, s_out, s_halt, s_fault
  } state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic [3:0] op;
  logic timeout, fin, retire, in_wait;
  assign in_wait = state == s_f_wait || state == s_o_wait;
  assign timeout = wait_cnt == 8'(WAIT_MAX - 1) && !MEM_ACK;
  assign fin = (state == s_decode && OPCODE == 4'h9) || (state == s_o_load && op == 4'h0) ||
               state == s_alu_wb || state == s_out;
  assign retire = fin || (state == s_decode && OPCODE == 4'hF);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= s_idle;
      wait_cnt <= 8'd0;
      RETIRED <= 8'd0;
      op <= 4'd0;
    end else begin
      state <= state_nx;
      wait_cnt <= in_wait ? wait_cnt + 8'd1 : 8'd0;
      RETIRED <= RETIRED + 8'(retire);
      op <= state == s_decode ? OPCODE : op;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      s_idle:   state_nx = RUN ? s_f_addr : s_idle;
      s_f_addr: state_nx = s_f_wait;
      s_f_wait: state_nx = MEM_ACK ? s_f_load : timeout ? s_fault : s_f_wait;
      s_f_load: state_nx = s_decode;
      s_decode: state_nx = OPCODE <= 4'd5 ? s_o_addr : OPCODE <= 4'd8 ? s_alu_wb :
                           OPCODE == 4'hE ? s_out : OPCODE == 4'hF ? s_halt : s_fault;
      s_o_addr: state_nx = s_o_wait;
      s_o_wait: state_nx = MEM_ACK ? s_o_load : timeout ? s_fault : s_o_wait;
      s_o_load: state_nx = s_alu_wb;
      s_halt:   state_nx = s_halt;
      s_fault:  state_nx = s_fault;
      default:  state_nx = s_idle;
    endcase
    if (fin) state_nx = RUN ? s_f_addr : s_idle;
  end
  always_comb begin
    OE_PC = state == s_f_addr;
    PC_INC = state == s_f_load;
    WE_MAR = state == s_f_addr || state == s_o_addr;
    MEM_RD = state == s_f_wait || state == s_f_load || state == s_o_wait || state == s_o_load;
    OE_MEM = state == s_f_load || state == s_o_load;
    WE_IR = state == s_f_load;
    OE_IR = state == s_o_addr;
    WE_ACC = (state == s_o_load && op == 4'h0) || state == s_alu_wb;
    OE_ACC = state == s_out;
    WE_BREG = state == s_o_load && op != 4'h0;
    OE_ALU = state == s_alu_wb;
    ALU_OP = state != s_alu_wb ? 3'b000 :
             op == 4'h2 ? 3'b001 : op == 4'h3 ? 3'b101 : op == 4'h4 ? 3'b110 :
             op == 4'h5 ? 3'b111 : op == 4'h6 ? 3'b011 : op == 4'h7 ? 3'b010 :
             op == 4'h8 ? 3'b100 : 3'b000;
    WE_OR = state == s_out;
    HALTED = state == s_halt;
    FAULT = state == s_fault;
    STATE = state;
  end
endmodule

// File: tb/tb_sap_sequencer.sv
// tb_sap_sequencer: bus/memory environment plus ISA-level reference model for sap_sequencer
module tb_sap_sequencer;
  localparam int WM = 4;
  logic CLK = 1'b0, RESET = 1'b1, RUN = 1'b0, MEM_ACK;
  logic [3:0] OPCODE, STATE;
  logic OE_PC, PC_INC, WE_MAR, MEM_RD, OE_MEM, WE_IR, OE_IR, WE_ACC, OE_ACC, WE_BREG, OE_ALU, WE_OR;
  logic HALTED, FAULT;
  logic [2:0] ALU_OP;
  logic [7:0] RETIRED;
  sap_sequencer #(.WAIT_MAX(WM)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .OPCODE(OPCODE), .MEM_ACK(MEM_ACK),
    .OE_PC(OE_PC), .PC_INC(PC_INC), .WE_MAR(WE_MAR), .MEM_RD(MEM_RD), .OE_MEM(OE_MEM),
    .WE_IR(WE_IR), .OE_IR(OE_IR), .WE_ACC(WE_ACC), .OE_ACC(OE_ACC), .WE_BREG(WE_BREG),
    .OE_ALU(OE_ALU), .ALU_OP(ALU_OP), .WE_OR(WE_OR), .HALTED(HALTED), .FAULT(FAULT),
    .STATE(STATE), .RETIRED(RETIRED)
  );
  always #5 CLK = ~CLK;
  logic [7:0] mem [256];
  logic [7:0] pc, mar, ir, acc, breg, outr, alu, bus, rd_cnt, d_f = 8'd0, d_op = 8'd0;
  logic opnd, nack_op = 1'b0;
  logic [16:0] strobes;
  logic [7:0] m_pc, m_acc, m_out, m_ret;
  int vecs = 0, errs = 0;
  logic [3:0] ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE};
  always_comb
    case (ALU_OP)
      3'b000: alu = acc + breg;
      3'b001: alu = acc - breg;
      3'b010: alu = acc - 8'd1;
      3'b011: alu = acc + 8'd1;
      3'b100: alu = ~acc;
      3'b101: alu = acc & breg;
      3'b110: alu = acc | breg;
      default: alu = acc ^ breg;
    endcase
  assign bus = OE_PC ? pc : OE_MEM ? mem[mar] : OE_IR ? {4'h0, ir[3:0]} : OE_ACC ? acc : OE_ALU ? alu : 8'h00;
  assign OPCODE = ir[7:4];
  assign MEM_ACK = MEM_RD && !(opnd && nack_op) && rd_cnt >= (opnd ? d_op : d_f);
  assign strobes = {OE_PC, PC_INC, WE_MAR, MEM_RD, OE_MEM, WE_IR, OE_IR, WE_ACC, OE_ACC,
                    WE_BREG, OE_ALU, ALU_OP, WE_OR, HALTED, FAULT};
  always @(posedge CLK)
    if (RESET) begin
      {pc, mar, ir, acc, breg, outr, rd_cnt} <= '0;
      opnd <= 1'b0;
    end else begin
      if (PC_INC) pc <= pc + 8'd1;
      if (WE_MAR) mar <= bus;
      if (WE_IR) ir <= bus;
      if (WE_ACC) acc <= bus;
      if (WE_BREG) breg <= bus;
      if (WE_OR) outr <= bus;
      rd_cnt <= MEM_RD ? rd_cnt + 8'd1 : 8'd0;
      if (OE_IR) opnd <= 1'b1;
      else if (OE_PC) opnd <= 1'b0;
    end
  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
    chk("oe_at_most_one", int'($countones({OE_PC, OE_MEM, OE_IR, OE_ACC, OE_ALU}) <= 1), 1);
    chk("aluop_zero_off_wb", int'(OE_ALU || ALU_OP == 3'b000), 1);
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    RUN = 1'b0;
    nack_op = 1'b0;
    tick();
    tick();
    chk("rst_state", STATE, 0);
    chk("rst_strobes", strobes, 0);
    chk("rst_retired", RETIRED, 0);
    RESET = 1'b0;
    {m_pc, m_acc, m_out, m_ret} = '0;
  endtask
  // ISA-level effect and cycle cost of the instruction at m_pc
  task automatic model(input logic [7:0] df, input logic [7:0] dop, output int lat);
    logic [7:0] ins, v;
    ins = mem[m_pc];
    v = mem[{4'h0, ins[3:0]}];
    lat = int'(df) + 4;
    m_pc++;
    m_ret++;
    if (ins[7:4] <= 4'd5) lat += int'(dop) + (ins[7:4] == 4'h0 ? 3 : 4);
    else if (ins[7:4] <= 4'd8 || ins[7:4] == 4'hE) lat += 1;
    case (ins[7:4])
      4'h0: m_acc = v;
      4'h1: m_acc = m_acc + v;
      4'h2: m_acc = m_acc - v;
      4'h3: m_acc = m_acc & v;
      4'h4: m_acc = m_acc | v;
      4'h5: m_acc = m_acc ^ v;
      4'h6: m_acc = m_acc + 8'd1;
      4'h7: m_acc = m_acc - 8'd1;
      4'h8: m_acc = ~m_acc;
      4'hE: m_out = m_acc;
      default: ;
    endcase
  endtask
  task automatic run_one(input logic [7:0] df, input logic [7:0] dop);
    int lat, n;
    logic [7:0] r0;
    d_f = df;
    d_op = dop;
    r0 = RETIRED;
    model(df, dop, lat);
    n = 0;
    while (RETIRED === r0 && !FAULT && n < 64) begin
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("acc", acc, m_acc);
    chk("out_reg", outr, m_out);
    chk("pc", pc, m_pc);
    chk("retired", RETIRED, m_ret);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h90;
    // LDA 5 then ADD 6, then HLT
    mem[0] = 8'h05; mem[5] = 8'h2A; mem[1] = 8'h16; mem[6] = 8'h03; mem[2] = 8'hF0;
    do_reset();
    tick();
    chk("idle_no_run", STATE, 0);
    RUN = 1'b1;
    tick();
    chk("start_f_addr", STATE, 1);
    run_one(0, 0);
    chk("lda_acc", acc, 8'h2A);
    run_one(0, 0);
    chk("add_acc", acc, 8'h2D);
    run_one(0, 0);
    chk("hlt_halted", HALTED, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hlt_no_rd", MEM_RD, 0);
      chk("hlt_state", STATE, 10);
    end
    // illegal opcode
    mem[0] = 8'hB0;
    do_reset();
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("ill_decode", STATE, 4);
    tick();
    chk("ill_fault", FAULT, 1);
    chk("ill_state", STATE, 11);
    for (int i = 0; i < 5; i++) tick();
    chk("ill_sticky", FAULT, 1);
    chk("ill_no_retire", RETIRED, 0);
    // operand read timeout after one NOP
    mem[0] = 8'h90; mem[1] = 8'h07;
    do_reset();
    nack_op = 1'b1;
    RUN = 1'b1;
    tick();
    run_one(0, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("to_last_wait", STATE, 6);
    tick();
    chk("to_fault", FAULT, 1);
    chk("to_retired", RETIRED, 1);
    nack_op = 1'b0;
    // RUN dropped during ALU_WB of INC
    mem[0] = 8'h60; mem[1] = 8'h90;
    do_reset();
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("inc_wb", STATE, 8);
    RUN = 1'b0;
    tick();
    chk("drop_idle", STATE, 0);
    chk("drop_retired", RETIRED, 1);
    chk("drop_acc", acc, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("drop_stay_idle", STATE, 0);
    RUN = 1'b1;
    tick();
    chk("resume_state", STATE, 1);
    chk("resume_bus", bus, 1);
    // reset in O_WAIT
    mem[0] = 8'h90; mem[1] = 8'h03;
    do_reset();
    RUN = 1'b1;
    tick();
    run_one(0, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("owait", STATE, 6);
    RESET = 1'b1;
    tick();
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_strobes", strobes, 0);
    chk("mid_rst_retired", RETIRED, 0);
    RESET = 1'b0;
    RUN = 1'b0;
    // 256 NOPs wrap RETIRED
    for (int i = 0; i < 256; i++) mem[i] = 8'h90;
    do_reset();
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) run_one(8'($urandom_range(0, 3)), 0);
    chk("ret_255", RETIRED, 255);
    run_one(0, 0);
    chk("ret_wrap", RETIRED, 0);
    // random program ending in HLT
    for (int i = 0; i < 60; i++) mem[i] = {ops[$urandom_range(0, 10)], 4'($urandom_range(0, 15))};
    mem[60] = 8'hF0;
    do_reset();
    RUN = 1'b1;
    tick();
    for (int i = 0; i < 61; i++) run_one(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
    chk("rand_halted", HALTED, 1);
    chk("rand_no_fault", FAULT, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rand_hlt_no_rd", MEM_RD, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
